// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access sizes, FSM states and
// byte-lane geometry, plus the size-decode helper used by steering and alignment.
package mem_pkg;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10,  // 32-bit word on XLEN=64, reserved on XLEN=32
    DS_FULL = 2'b11
  } dsize_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int LANE_W     = 8;
  localparam int LANE_SHIFT = 3;   // log2(LANE_W): byte offset to bit offset
  localparam int HALF_BYTES = 2;
  localparam int WORD_BYTES = 4;

  // Bytes touched by an access; 0 marks the reserved encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] dsize, input int xlen);
    case (dsize)
      DS_BYTE: return 4'd1;
      DS_HALF: return 4'(HALF_BYTES);
      DS_WORD: return (xlen == 64) ? 4'(WORD_BYTES) : 4'd0;
      default: return 4'(xlen / LANE_W);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// Bundle of the memory stage's upstream, memory-bus and writeback signals.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface mem_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RW_W  = 5,
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_memwr;
  logic              in_memtoreg;
  logic              in_regwr;
  logic              in_branch;
  logic              in_zero;
  logic              in_loadext;
  logic [1:0]        in_dsize;
  logic [RW_W-1:0]   in_rw;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_storedata;
  logic [XLEN-1:0]   in_btarget;
  logic              flush;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  logic              out_valid;
  logic              out_regwr;
  logic              out_memtoreg;
  logic [RW_W-1:0]   out_rw;
  logic [XLEN-1:0]   out_result;
  logic [XLEN-1:0]   out_execresult;
  logic              pcsrc;
  logic [XLEN-1:0]   out_btarget;
  logic              misalign;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_memwr, in_memtoreg, in_regwr, in_branch, in_zero, in_loadext,
           in_dsize, in_rw, in_addr, in_storedata, in_btarget, flush,
           mem_ready, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           out_valid, out_regwr, out_memtoreg, out_rw, out_result, out_execresult,
           pcsrc, out_btarget, misalign, stall_cnt
  );

  modport master (
    output in_valid, in_memwr, in_memtoreg, in_regwr, in_branch, in_zero, in_loadext,
           in_dsize, in_rw, in_addr, in_storedata, in_btarget, flush,
           mem_ready, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           out_valid, out_regwr, out_memtoreg, out_rw, out_result, out_execresult,
           pcsrc, out_btarget, misalign, stall_cnt
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: stores move data up into their lanes, loads shift down
// and zero/sign-extend. Purely combinational; store_i picks the direction.
module mem_align
  import mem_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN / 8),
  localparam int BE_W  = XLEN / 8
) (
  input  logic             store_i,
  input  logic [1:0]       dsize_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic             ext_i,
  input  logic [XLEN-1:0]  data_i,
  output logic [XLEN-1:0]  data_o,
  output logic [BE_W-1:0]  be_o
);

  localparam logic [XLEN-1:0] ONE    = XLEN'(1);
  localparam logic [BE_W-1:0] BE_ONE = BE_W'(1);

  logic [3:0]             nbytes;
  logic [OFF_W+LANE_SHIFT-1:0] shamt;
  logic [XLEN-1:0]        size_mask;
  logic [XLEN-1:0]        sign_mask;
  logic [XLEN-1:0]        shifted;
  logic [BE_W-1:0]        be_mask;
  logic                   sign;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no path leaves
    // one holding its old value, which would infer a latch.
    nbytes    = size_bytes(dsize_i, XLEN);
    shamt     = {offset_i, {LANE_SHIFT{1'b0}}};
    size_mask = '0;
    be_mask   = '0;
    data_o    = '0;

    // Full-width accesses would overflow the shift, so they take all-ones directly.
    if (nbytes == 4'(BE_W)) begin
      size_mask = '1;
      be_mask   = '1;
    end else begin
      size_mask = (ONE << {nbytes, {LANE_SHIFT{1'b0}}}) - ONE;
      be_mask   = (BE_ONE << nbytes) - BE_ONE;
    end

    sign_mask = size_mask ^ (size_mask >> 1);
    shifted   = data_i >> shamt;
    sign      = |(shifted & sign_mask);
    be_o      = be_mask << offset_i;

    if (store_i) begin
      data_o = (data_i & size_mask) << shamt;
    end else if (ext_i && sign) begin
      data_o = (shifted & size_mask) | ~size_mask;
    end else begin
      data_o = shifted & size_mask;
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Pipeline MEM stage: registers the EX result, performs at most one memory
// access with a valid/ready bus, and presents a one-cycle writeback result.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RW_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_stage_pipe_if.slave  bus
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int BE_W  = XLEN / 8;

  typedef struct packed {
    logic            memwr;
    logic            memtoreg;
    logic            regwr;
    logic            branch;
    logic            zero;
    logic            loadext;
    logic [1:0]      dsize;
    logic [RW_W-1:0] rw;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] storedata;
    logic [XLEN-1:0] btarget;
    logic            misalign;
  } stage_t;

  state_e           state_q, state_d;
  stage_t           stage_q, stage_d;
  logic             flushed_q, flushed_d;
  logic [XLEN-1:0]  load_q, load_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             req;
  logic             done;
  logic             valid;
  logic             capture;
  logic             in_mem_op;
  logic             in_misalign;
  logic [3:0]       in_nbytes;
  logic [OFF_W-1:0] in_align_mask;

  logic [XLEN-1:0]  st_data;
  logic [XLEN-1:0]  ld_data;
  logic [BE_W-1:0]  st_be;
  logic [BE_W-1:0]  ld_be;

  assign req   = (state_q == ST_ACCESS);
  assign done  = (state_q == ST_DONE);
  assign valid = done & ~bus.flush;

  assign capture = bus.in_valid & ~req & ~bus.flush;

  // Alignment is judged on the incoming address so a bad access never reaches ACCESS.
  always_comb begin
    in_nbytes     = size_bytes(bus.in_dsize, XLEN);
    in_align_mask = (in_nbytes == 4'd0) ? '0 : OFF_W'(in_nbytes - 4'd1);
    in_mem_op     = bus.in_memwr | bus.in_memtoreg;
    in_misalign   = in_mem_op & (|(bus.in_addr[OFF_W-1:0] & in_align_mask));
  end

  mem_align #(.XLEN(XLEN)) u_store_align (
    .store_i  (1'b1),
    .dsize_i  (stage_q.dsize),
    .offset_i (stage_q.addr[OFF_W-1:0]),
    .ext_i    (1'b0),
    .data_i   (stage_q.storedata),
    .data_o   (st_data),
    .be_o     (st_be)
  );

  mem_align #(.XLEN(XLEN)) u_load_align (
    .store_i  (1'b0),
    .dsize_i  (stage_q.dsize),
    .offset_i (stage_q.addr[OFF_W-1:0]),
    .ext_i    (stage_q.loadext),
    .data_i   (bus.mem_rdata),
    .data_o   (ld_data),
    .be_o     (ld_be)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    flushed_d = flushed_q;
    load_d    = load_q;
    stall_d   = stall_q;

    case (state_q)
      ST_ACCESS: begin
        // A flush cannot abort a bus access in flight; it only poisons its writeback.
        if (bus.flush) flushed_d = 1'b1;
        if (!bus.mem_ready && stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (bus.mem_ready) begin
          load_d  = ld_data;
          state_d = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (capture) begin
          state_d            = (in_mem_op && !in_misalign) ? ST_ACCESS : ST_DONE;
          stage_d.memwr      = bus.in_memwr;
          stage_d.memtoreg   = bus.in_memtoreg;
          stage_d.regwr      = bus.in_regwr;
          stage_d.branch     = bus.in_branch;
          stage_d.zero       = bus.in_zero;
          stage_d.loadext    = bus.in_loadext;
          stage_d.dsize      = bus.in_dsize;
          stage_d.rw         = bus.in_rw;
          stage_d.addr       = bus.in_addr;
          stage_d.storedata  = bus.in_storedata;
          stage_d.btarget    = bus.in_btarget;
          stage_d.misalign   = in_misalign;
          flushed_d          = 1'b0;
          load_d             = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every register sample the pre-edge
    // values, independent of statement order.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      flushed_q <= 1'b0;
      load_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      flushed_q <= flushed_d;
      load_q    <= load_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.in_ready  = ~req;

  assign bus.mem_req   = req;
  assign bus.mem_we    = req & stage_q.memwr;
  assign bus.mem_addr  = req ? {stage_q.addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.mem_wdata = req ? st_data : '0;
  assign bus.mem_be    = req ? (stage_q.memwr ? st_be : ld_be) : '0;

  assign bus.out_valid      = valid;
  assign bus.out_regwr      = valid & stage_q.regwr & ~stage_q.misalign & ~flushed_q;
  assign bus.out_memtoreg   = stage_q.memtoreg;
  assign bus.out_rw         = stage_q.rw;
  assign bus.out_result     = stage_q.memtoreg ? load_q : stage_q.addr;
  assign bus.out_execresult = stage_q.addr;
  assign bus.out_btarget    = stage_q.btarget;
  assign bus.pcsrc          = valid & stage_q.branch & stage_q.zero & ~flushed_q;
  assign bus.misalign       = valid & stage_q.misalign;
  assign bus.stall_cnt      = stall_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a 32-bit instance for the main scenarios
// and a 64-bit instance (narrow stall counter) for word loads and saturation.
module tb_mem_stage_pipe;
  import mem_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_stage_pipe_if #(.XLEN(32), .RW_W(5), .CNT_W(16)) b32 ();
  mem_stage_pipe_if #(.XLEN(64), .RW_W(5), .CNT_W(2))  b64 ();

  mem_stage_pipe #(.XLEN(32), .RW_W(5), .CNT_W(16)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  mem_stage_pipe #(.XLEN(64), .RW_W(5), .CNT_W(2))  dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, mw, mtr, rwe, br, z, lx, input logic [1:0] ds,
                         input logic [4:0] rd, input logic [31:0] a, sd, bt);
    b32.in_valid = v; b32.in_memwr = mw; b32.in_memtoreg = mtr; b32.in_regwr = rwe;
    b32.in_branch = br; b32.in_zero = z; b32.in_loadext = lx; b32.in_dsize = ds;
    b32.in_rw = rd; b32.in_addr = a; b32.in_storedata = sd; b32.in_btarget = bt;
  endtask

  task automatic drive64(input logic v, mw, mtr, rwe, br, z, lx, input logic [1:0] ds,
                         input logic [4:0] rd, input logic [63:0] a, sd, bt);
    b64.in_valid = v; b64.in_memwr = mw; b64.in_memtoreg = mtr; b64.in_regwr = rwe;
    b64.in_branch = br; b64.in_zero = z; b64.in_loadext = lx; b64.in_dsize = ds;
    b64.in_rw = rd; b64.in_addr = a; b64.in_storedata = sd; b64.in_btarget = bt;
  endtask

  task automatic idle32();
    drive32(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    b32.flush = 1'b0; b32.mem_ready = 1'b0; b32.mem_rdata = '0;
  endtask

  task automatic idle64();
    drive64(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 64'h0, 64'h0, 64'h0);
    b64.flush = 1'b0; b64.mem_ready = 1'b0; b64.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle32();
    idle64();
    step(); step();
    total++; if ({b32.in_ready, b32.out_valid, b32.mem_req, b32.pcsrc, b32.misalign, b32.out_regwr} !== 6'b100000) begin bad++; $display("FAIL rst_ctl32: got %b expected 100000", {b32.in_ready, b32.out_valid, b32.mem_req, b32.pcsrc, b32.misalign, b32.out_regwr}); end
    total++; if (b32.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall32: got %0d expected 0", b32.stall_cnt); end
    total++; if ({b32.out_result, b32.out_btarget, b32.mem_addr} !== 96'h0) begin bad++; $display("FAIL rst_data32: got %h expected 0", {b32.out_result, b32.out_btarget, b32.mem_addr}); end
    total++; if ({b64.in_ready, b64.out_valid, b64.mem_req} !== 3'b100) begin bad++; $display("FAIL rst_ctl64: got %b expected 100", {b64.in_ready, b64.out_valid, b64.mem_req}); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_load();
    step();
    idle32();
    drive32(1, 0, 1, 1, 0, 0, 1, DS_BYTE, 5'd5, 32'h1003, 32'h0, 32'h0);
    #1;
    total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL bl_ready_c0: got %b expected 1", b32.in_ready); end
    step();
    b32.in_valid = 1'b0;
    #1;
    total++; if ({b32.mem_req, b32.mem_we, b32.in_ready} !== 3'b100) begin bad++; $display("FAIL bl_req: got %b expected 100", {b32.mem_req, b32.mem_we, b32.in_ready}); end
    total++; if (b32.mem_addr !== 32'h1000) begin bad++; $display("FAIL bl_addr: got %h expected 00001000", b32.mem_addr); end
    total++; if (b32.mem_be !== 4'b1000) begin bad++; $display("FAIL bl_be: got %b expected 1000", b32.mem_be); end
    step();
    step();
    b32.mem_ready = 1'b1;
    b32.mem_rdata = 32'h80123456;
    #1;
    total++; if ({b32.out_valid, b32.mem_req, b32.stall_cnt} !== {2'b01, 16'd2}) begin bad++; $display("FAIL bl_wait: got valid=%b req=%b stall=%0d expected valid=0 req=1 stall=2", b32.out_valid, b32.mem_req, b32.stall_cnt); end
    step();
    b32.mem_ready = 1'b0;
    #1;
    total++; if ({b32.out_valid, b32.out_regwr, b32.mem_req} !== 3'b110) begin bad++; $display("FAIL bl_done: got %b expected 110", {b32.out_valid, b32.out_regwr, b32.mem_req}); end
    total++; if (b32.out_result !== 32'hFFFFFF80) begin bad++; $display("FAIL bl_result: got %h expected ffffff80", b32.out_result); end
    total++; if ({b32.out_rw, b32.stall_cnt} !== {5'd5, 16'd2}) begin bad++; $display("FAIL bl_rw_stall: got rw=%0d stall=%0d expected rw=5 stall=2", b32.out_rw, b32.stall_cnt); end
    step();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL bl_one_cycle: got %b expected 0", b32.out_valid); end
  endtask

  task automatic test_half_store();
    step();
    idle32();
    drive32(1, 1, 0, 0, 0, 0, 0, DS_HALF, 5'd0, 32'h2002, 32'h0000BEEF, 32'h0);
    b32.mem_ready = 1'b1;
    step();
    b32.in_valid = 1'b0;
    #1;
    total++; if ({b32.mem_req, b32.mem_we} !== 2'b11) begin bad++; $display("FAIL hs_req_we: got %b expected 11", {b32.mem_req, b32.mem_we}); end
    total++; if (b32.mem_be !== 4'b1100) begin bad++; $display("FAIL hs_be: got %b expected 1100", b32.mem_be); end
    total++; if (b32.mem_wdata !== 32'hBEEF0000) begin bad++; $display("FAIL hs_wdata: got %h expected beef0000", b32.mem_wdata); end
    total++; if (b32.mem_addr !== 32'h2000) begin bad++; $display("FAIL hs_addr: got %h expected 00002000", b32.mem_addr); end
    step();
    total++; if ({b32.out_valid, b32.out_regwr, b32.out_result} !== {2'b10, 32'h2002}) begin bad++; $display("FAIL hs_done: got valid=%b regwr=%b result=%h expected 1 0 00002002", b32.out_valid, b32.out_regwr, b32.out_result); end
  endtask

  task automatic test_misaligned();
    step();
    idle32();
    drive32(1, 0, 1, 1, 0, 0, 0, DS_FULL, 5'd7, 32'h3001, 32'h0, 32'h0);
    step();
    b32.in_valid = 1'b0;
    #1;
    total++; if ({b32.mem_req, b32.out_valid, b32.misalign, b32.out_regwr} !== 4'b0110) begin bad++; $display("FAIL mis_done: got %b expected 0110", {b32.mem_req, b32.out_valid, b32.misalign, b32.out_regwr}); end
    total++; if (b32.stall_cnt !== 16'd2) begin bad++; $display("FAIL mis_stall: got %0d expected 2", b32.stall_cnt); end
    step();
    total++; if ({b32.out_valid, b32.misalign, b32.mem_req} !== 3'b000) begin bad++; $display("FAIL mis_after: got %b expected 000", {b32.out_valid, b32.misalign, b32.mem_req}); end
  endtask

  task automatic test_branch();
    step();
    idle32();
    drive32(1, 0, 0, 0, 1, 1, 0, DS_BYTE, 5'd0, 32'h10, 32'h0, 32'h400);
    step();
    drive32(1, 0, 0, 0, 1, 0, 0, DS_BYTE, 5'd0, 32'h14, 32'h0, 32'h800);
    #1;
    total++; if ({b32.out_valid, b32.pcsrc} !== 2'b11) begin bad++; $display("FAIL br_taken: got %b expected 11", {b32.out_valid, b32.pcsrc}); end
    total++; if (b32.out_btarget !== 32'h400) begin bad++; $display("FAIL br_target: got %h expected 00000400", b32.out_btarget); end
    step();
    b32.in_valid = 1'b0;
    #1;
    total++; if ({b32.out_valid, b32.pcsrc, b32.out_btarget} !== {2'b10, 32'h800}) begin bad++; $display("FAIL br_nottaken: got valid=%b pcsrc=%b target=%h expected 1 0 00000800", b32.out_valid, b32.pcsrc, b32.out_btarget); end
    step();
    total++; if ({b32.out_valid, b32.pcsrc} !== 2'b00) begin bad++; $display("FAIL br_after: got %b expected 00", {b32.out_valid, b32.pcsrc}); end
  endtask

  task automatic test_flush();
    step();
    idle32();
    drive32(1, 0, 1, 1, 0, 0, 0, DS_FULL, 5'd9, 32'h4000, 32'h0, 32'h0);
    step();
    b32.in_valid = 1'b0;
    b32.flush = 1'b1;
    #1;
    total++; if (b32.mem_req !== 1'b1) begin bad++; $display("FAIL fl_req: got %b expected 1", b32.mem_req); end
    step();
    b32.flush = 1'b0;
    b32.mem_ready = 1'b1;
    b32.mem_rdata = 32'hCAFEF00D;
    step();
    b32.mem_ready = 1'b0;
    #1;
    total++; if ({b32.out_valid, b32.out_regwr, b32.pcsrc} !== 3'b100) begin bad++; $display("FAIL fl_access_done: got %b expected 100", {b32.out_valid, b32.out_regwr, b32.pcsrc}); end
    total++; if (b32.out_result !== 32'hCAFEF00D) begin bad++; $display("FAIL fl_result: got %h expected cafef00d", b32.out_result); end
    total++; if (b32.stall_cnt !== 16'd3) begin bad++; $display("FAIL fl_stall: got %0d expected 3", b32.stall_cnt); end
    step();
    drive32(1, 0, 0, 1, 0, 0, 0, DS_BYTE, 5'd3, 32'h55, 32'h0, 32'h0);
    b32.flush = 1'b1;
    step();
    b32.flush = 1'b0;
    drive32(1, 0, 0, 1, 0, 0, 0, DS_BYTE, 5'd3, 32'h66, 32'h0, 32'h0);
    #1;
    total++; if ({b32.out_valid, b32.out_execresult} !== {1'b0, 32'h4000}) begin bad++; $display("FAIL fl_idle: got valid=%b exec=%h expected 0 00004000", b32.out_valid, b32.out_execresult); end
    step();
    b32.in_valid = 1'b0;
    b32.flush = 1'b1;
    #1;
    total++; if ({b32.out_valid, b32.out_regwr, b32.out_execresult} !== {2'b00, 32'h66}) begin bad++; $display("FAIL fl_done: got valid=%b regwr=%b exec=%h expected 0 0 00000066", b32.out_valid, b32.out_regwr, b32.out_execresult); end
    step();
    b32.flush = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    step();
    idle32();
    drive32(1, 0, 1, 1, 0, 0, 0, DS_FULL, 5'd1, 32'h5000, 32'h0, 32'h0);
    step();
    b32.in_valid = 1'b0;
    #1;
    total++; if (b32.mem_req !== 1'b1) begin bad++; $display("FAIL rma_req: got %b expected 1", b32.mem_req); end
    rst_n = 1'b0;
    step();
    total++; if ({b32.mem_req, b32.out_valid, b32.in_ready, b32.stall_cnt} !== {3'b001, 16'd0}) begin bad++; $display("FAIL rma_drop: got req=%b valid=%b ready=%b stall=%0d expected 0 0 1 0", b32.mem_req, b32.out_valid, b32.in_ready, b32.stall_cnt); end
    rst_n = 1'b1;
    step();
    total++; if ({b32.mem_req, b32.out_valid} !== 2'b00) begin bad++; $display("FAIL rma_after: got %b expected 00", {b32.mem_req, b32.out_valid}); end
  endtask

  task automatic test_xlen64_word();
    step();
    idle64();
    drive64(1, 0, 1, 1, 0, 0, 0, DS_WORD, 5'd2, 64'h8004, 64'h0, 64'h0);
    b64.mem_ready = 1'b1;
    b64.mem_rdata = 64'h89ABCDEF_12345678;
    step();
    b64.in_valid = 1'b0;
    #1;
    total++; if ({b64.mem_req, b64.mem_be} !== {1'b1, 8'hF0}) begin bad++; $display("FAIL x64_be: got req=%b be=%b expected 1 11110000", b64.mem_req, b64.mem_be); end
    total++; if (b64.mem_addr !== 64'h8000) begin bad++; $display("FAIL x64_addr: got %h expected 0000000000008000", b64.mem_addr); end
    step();
    total++; if ({b64.out_valid, b64.out_result} !== {1'b1, 64'h00000000_89ABCDEF}) begin bad++; $display("FAIL x64_result: got valid=%b result=%h expected 1 0000000089abcdef", b64.out_valid, b64.out_result); end
  endtask

  task automatic test_back_to_back();
    step();
    idle64();
    drive64(1, 0, 0, 1, 0, 0, 0, DS_BYTE, 5'd1, 64'h111, 64'h0, 64'h0);
    step();
    drive64(1, 0, 0, 1, 0, 0, 0, DS_BYTE, 5'd1, 64'h222, 64'h0, 64'h0);
    #1;
    total++; if ({b64.out_valid, b64.in_ready, b64.out_result} !== {2'b11, 64'h111}) begin bad++; $display("FAIL b2b_first: got valid=%b ready=%b result=%h expected 1 1 111", b64.out_valid, b64.in_ready, b64.out_result); end
    step();
    b64.in_valid = 1'b0;
    #1;
    total++; if ({b64.out_valid, b64.out_result} !== {1'b1, 64'h222}) begin bad++; $display("FAIL b2b_second: got valid=%b result=%h expected 1 222", b64.out_valid, b64.out_result); end
    step();
    total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b expected 0", b64.out_valid); end
  endtask

  task automatic test_stall_saturate();
    step();
    idle64();
    drive64(1, 0, 1, 1, 0, 0, 0, DS_FULL, 5'd4, 64'h100, 64'h0, 64'h0);
    step();
    b64.in_valid = 1'b0;
    step();
    step();
    total++; if (b64.stall_cnt !== 2'd2) begin bad++; $display("FAIL sat_mid: got %0d expected 2", b64.stall_cnt); end
    repeat (3) step();
    total++; if (b64.stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d expected 3", b64.stall_cnt); end
    b64.mem_ready = 1'b1;
    b64.mem_rdata = 64'hFEED;
    step();
    b64.mem_ready = 1'b0;
    #1;
    total++; if ({b64.out_valid, b64.out_result, b64.stall_cnt} !== {1'b1, 64'hFEED, 2'd3}) begin bad++; $display("FAIL sat_done: got valid=%b result=%h stall=%0d expected 1 feed 3", b64.out_valid, b64.out_result, b64.stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_branch();
    test_flush();
    test_reset_mid_access();
    test_xlen64_word();
    test_back_to_back();
    test_stall_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width; legal values 32 and 64.
REQ-002 SHALL have parameter RW_W, default 5, destination register index width.
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have ports clk in 1 (sole clock, rising edge) and rst_n in 1 (synchronous, active-low reset).
REQ-005 SHALL have port in_valid in 1, meaning the EX result is presented.
REQ-006 SHALL have port in_ready out 1, meaning the stage accepts this cycle; low stalls upstream.
REQ-007 SHALL have ports in_memwr, in_memtoreg, in_regwr, in_branch, in_zero and in_loadext, each in 1, as control bits; in_loadext 1 = sign-extend.
REQ-008 SHALL have ports in_dsize in 2, in_rw in RW_W, and in_addr, in_storedata and in_btarget, each in XLEN.
REQ-009 SHALL have port flush in 1, meaning kill the pending or incoming instruction.
REQ-010 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out XLEN, mem_wdata out XLEN, mem_be out XLEN/8, mem_ready in 1 and mem_rdata in XLEN.
REQ-011 SHALL have ports out_valid, out_regwr and out_memtoreg, each out 1.
REQ-012 SHALL have ports out_rw out RW_W, out_result out XLEN and out_execresult out XLEN.
REQ-013 SHALL have ports pcsrc out 1, out_btarget out XLEN, misalign out 1 and stall_cnt out CNT_W.

Function
REQ-014 SHALL capture all in_* fields into the stage register on a rising edge with in_valid & in_ready & !flush.
REQ-015 SHALL implement FSM IDLE, ACCESS and DONE. From IDLE, a capture with in_memwr|in_memtoreg and aligned access goes to ACCESS; any other capture goes to DONE.
REQ-016 SHALL, in ACCESS, hold mem_req=1 with mem_addr, mem_we, mem_be and mem_wdata stable until mem_ready is sampled 1. On that edge it registers the aligned load data and goes to DONE.
REQ-017 SHALL assert out_valid for exactly one cycle in DONE, then return to IDLE. DONE SHALL accept a new capture, making DONE-to-DONE/ACCESS back-to-back legal.
REQ-018 SHALL drive in_ready = (state != ACCESS).
REQ-019 SHALL give latency of 1 cycle capture-to-out_valid for non-memory ops and 2+W for memory ops, where W is the number of cycles mem_ready is low.
REQ-020 SHALL use dsize encoding 00 byte, 01 half, 11 full XLEN, 10 word-32 (XLEN=64) or reserved (XLEN=32). Reserved SHALL give load result 0 and mem_be all zero.
REQ-021 SHALL place stores in byte lanes selected by addr[log2(XLEN/8)-1:0], with mem_be set for the accessed lanes only and mem_addr XLEN/8-aligned.
REQ-022 SHALL shift loads down from the lane and then zero- or sign-extend per loadext; full-width loads SHALL ignore loadext.
REQ-023 SHALL treat an access as misaligned if addr is not a multiple of its size. A misaligned access SHALL skip ACCESS, go to DONE with misalign=1, out_regwr=0 and no mem_req.
REQ-024 SHALL drive out_result as loaded data if memtoreg, else execresult. out_rw, out_memtoreg and out_btarget SHALL pass through from the stage register.
REQ-025 SHALL drive pcsrc = branch & zero, asserted only while out_valid.
REQ-026 SHALL give flush the following behaviour: in IDLE/DONE, it suppresses capture and out_valid that cycle. In ACCESS, the access completes (a store still writes) but the resulting DONE has out_regwr=0 and pcsrc=0.
REQ-027 SHALL increment stall_cnt each cycle in ACCESS with mem_ready=0, saturating at all-ones with no wrap.

Reset
REQ-028 SHALL, with rst_n=0 at a rising edge, set state to IDLE, clear the stage register, and drive all outputs to 0 except in_ready=1. stall_cnt SHALL be 0.
REQ-029 SHALL, when reset is asserted mid-ACCESS, drop mem_req next cycle with no out_valid. The memory side SHALL tolerate the abandoned request.

Structure
REQ-030 SHALL place the dsize encodings, FSM state encoding and lane-width localparams in shared package mem_pkg.
REQ-031 SHALL put lane steering and extension in combinational sub-module mem_align (params XLEN), instantiated once for store and once for load.

Verification
REQ-032 SHALL cover a byte load with sign extension: XLEN=32, addr=0x1003, dsize=00, loadext=1, rdata=0x80xxxxxx, mem_ready after 2 wait cycles -> out_result=0xFFFFFF80, out_valid at capture+4, stall_cnt=2.
REQ-033 SHALL cover a half store: addr=0x2002, dsize=01, storedata=0x0000BEEF -> mem_be=1100, mem_wdata=0xBEEF0000, mem_addr=0x2000, mem_we=1.
REQ-034 SHALL cover a misaligned word: addr=0x3001, dsize=11 -> no mem_req, misalign=1, out_regwr=0, out_valid at capture+1.
REQ-035 SHALL cover a branch: branch=1, zero=1, btarget=0x400 -> pcsrc=1 for one cycle with out_btarget=0x400. With zero=0 -> pcsrc=0.
REQ-036 SHALL cover flush during ACCESS of a load with regwr=1 -> access completes and out_valid=1 with out_regwr=0. With flush in IDLE -> no capture.
REQ-037 SHALL cover the XLEN=64 variant: dsize=10, addr=0x8004, loadext=0, rdata upper word=0x89ABCDEF -> out_result=0x0000000089ABCDEF. Back-to-back non-memory ops SHALL give out_valid on consecutive cycles.
